mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter that shares the single RAM port among REQS cache requesters (icache/dcache of each core).
- Sits between the caches and the RAM interface, in front of coherence control.
- Holds a grant for the whole multi-cycle RAM access, so no requester can starve another.
- Replaces fixed-priority d-before-i selection with fair, registered grant sequencing.

Parameters:
- REQS, 4: number of requesters; index i maps to core i/2, even = icache, odd = dcache. Legal range 2..8.
- TIMEOUT, 64: watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset; synchronous, active-low.
- req_ren  in  REQS  per-requester read request.
- req_wen  in  REQS  per-requester write request.
- req_addr  in  REQS*32  packed word_t addresses; requester i at [32i+31:32i].
- req_store  in  REQS*32  packed write data, same packing.
- req_wait  out  REQS  per-requester wait; 0 only for the owner in its completion cycle.
- req_load  out  32  read data broadcast to all requesters (= ramload).
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- owner  out  $clog2(REQS)  index of the current or last granted requester.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle watchdog pulse (MEM_ARB_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- All state updates on posedge CLK. nRST is sampled synchronously.
- State after reset:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - req_wait = all 1s, ramREN = 0, ramWEN = 0, ramaddr = 0, ramstore = 0, busy = 0, timeout = 0.
- Active request: req_act[i] = req_ren[i] | req_wen[i].
- IDLE state:
  - RAM enables are 0 and all req_wait are 1.
  - If any req_act is set, select the first active index scanning rr_ptr, rr_ptr+1, … modulo REQS.
  - Register that index into owner and go to GRANT.
  - If no request, stay in IDLE.
- GRANT state: RAM outputs are combinational from owner's live inputs.
  - ramaddr = req_addr[owner], ramstore = req_store[owner].
  - ramREN = req_ren[owner].
  - ramWEN = req_wen[owner] & ~req_ren[owner]; read wins if both are asserted.
  - busy = 1.
- Completion: GRANT with ramstate == ACCESS or ERROR.
  - req_wait[owner] = 0 for that cycle only.
  - Next state IDLE; rr_ptr <= (owner+1) mod REQS.
  - Wrap: owner = REQS-1 gives rr_ptr = 0.
- Abort: GRANT while owner's req_act = 0 (the requester withdrew).
  - RAM enables drop the same cycle.
  - Next state IDLE; rr_ptr is unchanged and no wait is released.
- Latency:
  - A request is seen at edge N; RAM enables are driven from cycle N+1.
  - With a RAM that answers ACCESS in the first cycle, the minimum transaction is 2 cycles.
  - One mandatory IDLE bubble follows each grant.
- Fairness: with all REQS requesting continuously, grants cycle 0,1,…,REQS-1,0,…
  - Worst-case wait is REQS-1 full transactions.
- Non-owners always see req_wait = 1. Requests arriving during GRANT are held off until the next IDLE.
- req_load = ramload at all times; requesters qualify it with their req_wait.
- Simultaneous request and completion in the same cycle: the new request is arbitrated in the following IDLE cycle using the updated rr_ptr.
- Reset mid-transaction: when nRST is low at an edge, force the reset state.
  - RAM enables are 0 from the next cycle.
  - The in-flight access is abandoned and no wait is released.
- ERROR is treated as completion; the requester detects it through its own ramstate view if needed.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entering GRANT and increments each GRANT cycle without completion.
  - When the count reaches TIMEOUT-1 without ACCESS/ERROR, timeout pulses high for one cycle and the state goes to IDLE.
  - rr_ptr <= owner+1 and req_wait stays 1, so a hung RAM cannot lock the bus.
- When undefined: no counter is built, timeout is tied 0, and GRANT waits indefinitely.

Test Plan:
- Reset: nRST=0 for 2 cycles with all req_ren=1 -> ramREN=0, req_wait=4'b1111, owner=0, busy=0.
- Single read: req_ren[2]=1, addr 0x0000_0040, RAM ACCESS after 3 BUSY cycles -> ramREN=1 with ramaddr=0x40 from cycle 1; req_wait[2]=0 only in cycle 4; rr_ptr=3 afterward.
- Round-robin: all four assert req_ren continuously, RAM 1-cycle ACCESS -> grant order 0,1,2,3,0; each req_wait drops once per 8 cycles.
- Read/write conflict: owner 1 asserts req_ren=1 and req_wen=1, store 0xDEAD_BEEF -> ramREN=1, ramWEN=0; then wen alone -> ramWEN=1, ramstore=0xDEADBEEF.
- Abort and reset: owner 3 drops req_ren mid-GRANT -> IDLE next cycle, rr_ptr unchanged; separately, nRST=0 during GRANT -> enables 0 next cycle, no wait release.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=8): ramstate held BUSY -> timeout high for exactly 1 cycle, in the cycle where the counter reads 7 (8 cycles after entering GRANT); next requester is granted; without the macro the bus stays in GRANT.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the caches, the round-robin RAM arbiter and the RAM port.
// "master" is the arbiter view; "slave" is the view of the caches plus RAM around it.
interface mem_bus_arbiter_if #(parameter int REQS = 4);
    logic [REQS-1:0]    req_ren;
    logic [REQS-1:0]    req_wen;
    logic [REQS*32-1:0] req_addr;
    logic [REQS*32-1:0] req_store;
    logic [REQS-1:0]    req_wait;
    logic [31:0]        req_load;
    logic [31:0]        ramaddr;
    logic [31:0]        ramstore;
    logic               ramREN;
    logic               ramWEN;
    logic [31:0]        ramload;
    logic [1:0]         ramstate;

    modport master (
        input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, ramaddr, ramstore, ramREN, ramWEN
    );

    modport slave (
        output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, ramaddr, ramstore, ramREN, ramWEN
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port among REQS cache requesters, holding each grant
// for the whole RAM access. Define MEM_ARB_TIMEOUT_EN to build the GRANT watchdog.
module mem_bus_arbiter #(
    parameter int REQS    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    nRST,
    mem_bus_arbiter_if.master       bus,
    output logic [$clog2(REQS)-1:0] owner,
    output logic                    busy,
    output logic                    timeout,
    output logic                    state_dbg
);
    localparam int PW = $clog2(REQS);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rr_ptr, rr_next, owner_next, pick;
    logic [REQS-1:0] act, wait_vec;
    logic            any_act, owner_act, done;
    logic [31:0]     addr_arr  [REQS];
    logic [31:0]     store_arr [REQS];

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= REQS) s = s - REQS;
        return PW'(s);
    endfunction

    assign act       = bus.req_ren | bus.req_wen;
    assign owner_act = act[owner];
    assign done      = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);
    assign state_dbg = state;
    assign bus.req_load = bus.ramload;
    assign bus.req_wait = wait_vec;

    always_comb begin
        for (int i = 0; i < REQS; i++) begin
            addr_arr[i]  = bus.req_addr[32*i +: 32];
            store_arr[i] = bus.req_store[32*i +: 32];
        end
    end

    // First active requester scanning upward from rr_ptr, wrapping at REQS.
    always_comb begin
        pick    = rr_ptr;
        any_act = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            if (!any_act && act[wrap_add(rr_ptr, k)]) begin
                any_act = 1'b1;
                pick    = wrap_add(rr_ptr, k);
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic          wd_hit;

    always_ff @(posedge CLK) begin
        if (!nRST)              wd_cnt <= '0;
        else if (state == IDLE) wd_cnt <= '0;
        else                    wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_hit = (wd_cnt == CW'(TIMEOUT - 1));
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_next;
            owner  <= owner_next;
        end
    end

    always_comb begin
        state_next   = state;
        rr_next      = rr_ptr;
        owner_next   = owner;
        wait_vec     = '1;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        busy         = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (any_act) begin
                    owner_next = pick;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                busy         = 1'b1;
                bus.ramaddr  = addr_arr[owner];
                bus.ramstore = store_arr[owner];
                bus.ramREN   = bus.req_ren[owner];
                bus.ramWEN   = bus.req_wen[owner] & ~bus.req_ren[owner];
                // A withdrawn request abandons the grant without moving the pointer.
                if (!owner_act) begin
                    state_next = IDLE;
                end else if (done) begin
                    wait_vec[owner] = 1'b0;
                    state_next      = IDLE;
                    rr_next         = wrap_add(owner, 1);
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                    rr_next    = wrap_add(owner, 1);
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset, single read, round-robin order,
// read/write conflict, abort, mid-grant reset and the GRANT watchdog or its absence.
module tb_mem_bus_arbiter;
    localparam int REQS    = 4;
    localparam int TIMEOUT = 8;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [1:0] owner;
    logic       busy, timeout, state_dbg;

    mem_bus_arbiter_if #(.REQS(REQS)) bus ();

    mem_bus_arbiter #(.REQS(REQS), .TIMEOUT(TIMEOUT)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .bus      (bus),
        .owner    (owner),
        .busy     (busy),
        .timeout  (timeout),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_tab [REQS];
    logic [31:0] e;
    logic [31:0] rd;
    logic [3:0]  ew;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] store);
        bus.req_ren[i]             = ren;
        bus.req_wen[i]             = wen;
        bus.req_addr[32*i +: 32]   = addr;
        bus.req_store[32*i +: 32]  = store;
    endtask

    task automatic clear_reqs();
        bus.req_ren = '0;
        bus.req_wen = '0;
    endtask

    initial begin
        bus.req_ren   = '1;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_store = '0;
        bus.ramload   = '0;
        bus.ramstate  = FREE;

        // Reset held two cycles with every requester reading.
        nRST = 1'b0;
        tick();
        tick();
        check("rst_ren",   bus.ramREN, 1'b0);
        check("rst_wen",   bus.ramWEN, 1'b0);
        check("rst_wait",  bus.req_wait, 4'hF);
        check("rst_owner", owner, 2'd0);
        check("rst_busy",  busy, 1'b0);
        check("rst_addr",  bus.ramaddr, 32'h0);
        check("rst_to",    timeout, 1'b0);
        nRST = 1'b1;
        clear_reqs();
        tick();

        // Single read from requester 2 with three BUSY cycles then ACCESS.
        set_req(2, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        bus.ramstate = BUSY;
        tick();
        check("rd_owner", owner, 2'd2);
        check("rd_ren",   bus.ramREN, 1'b1);
        check("rd_addr",  bus.ramaddr, 32'h40);
        check("rd_busy",  busy, 1'b1);
        check("rd_wait1", bus.req_wait, 4'hF);
        tick();
        tick();
        check("rd_wait3", bus.req_wait, 4'hF);
        rd = $urandom;
        bus.ramload  = rd;
        bus.ramstate = ACCESS;
        #1;
        check("rd_done",  bus.req_wait, 4'b1011);
        check("rd_load",  bus.req_load, rd);
        tick();
        clear_reqs();
        bus.ramstate = FREE;
        #1;
        check("rd_idle_wait", bus.req_wait, 4'hF);
        check("rd_idle_ren",  bus.ramREN, 1'b0);
        check("rd_idle_busy", busy, 1'b0);
        // rr_ptr must now be 3: requester 3 beats requester 0.
        set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_req(3, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        check("rr3_owner", owner, 2'd3);
        bus.ramstate = ACCESS;
        #1;
        check("rr3_wait", bus.req_wait, 4'b0111);
        tick();
        clear_reqs();
        bus.ramstate = FREE;
        tick();

        // All four requesting continuously, 1-cycle ACCESS: grants 0,1,2,3,0,1,2,3.
        for (int i = 0; i < REQS; i++) begin
            addr_tab[i] = $urandom;
            set_req(i, 1'b1, 1'b0, addr_tab[i], 32'h0);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < REQS; i++) exp_q.push_back(i);
        bus.ramstate = ACCESS;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (bus.req_wait != 4'hF) begin
                e  = exp_q.pop_front();
                ew = ~(4'b0001 << e[1:0]);
                check("rr_wait", bus.req_wait, ew);
                check("rr_addr", bus.ramaddr, addr_tab[e[1:0]]);
            end
        end
        check("rr_drained", exp_q.size(), 0);
        clear_reqs();
        bus.ramstate = FREE;
        tick();

        // Read/write conflict on requester 1; completion by ERROR.
        set_req(1, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        bus.ramstate = BUSY;
        tick();
        check("rw_owner", owner, 2'd1);
        check("rw_ren",   bus.ramREN, 1'b1);
        check("rw_wen",   bus.ramWEN, 1'b0);
        bus.req_ren[1] = 1'b0;
        #1;
        check("w_ren",   bus.ramREN, 1'b0);
        check("w_wen",   bus.ramWEN, 1'b1);
        check("w_store", bus.ramstore, 32'hDEAD_BEEF);
        bus.ramstate = ERROR;
        #1;
        check("w_err_wait", bus.req_wait, 4'b1101);
        tick();
        clear_reqs();
        bus.ramstate = FREE;
        tick();

        // Abort: requester 3 withdraws mid-grant; rr_ptr stays at 2.
        set_req(3, 1'b1, 1'b0, 32'h0000_0330, 32'h0);
        bus.ramstate = BUSY;
        tick();
        check("ab_owner", owner, 2'd3);
        bus.req_ren[3] = 1'b0;
        #1;
        check("ab_ren",  bus.ramREN, 1'b0);
        check("ab_wait", bus.req_wait, 4'hF);
        tick();
        check("ab_idle", busy, 1'b0);
        set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h0000_0220, 32'h0);
        tick();
        check("ab_next_owner", owner, 2'd2);

        // Reset in the middle of that grant.
        nRST = 1'b0;
        tick();
        check("mrst_ren",   bus.ramREN, 1'b0);
        check("mrst_wait",  bus.req_wait, 4'hF);
        check("mrst_busy",  busy, 1'b0);
        check("mrst_owner", owner, 2'd0);
        nRST = 1'b1;
        clear_reqs();
        tick();

        // RAM stuck BUSY with requester 1 granted and 2 waiting.
        set_req(1, 1'b1, 1'b0, 32'h0000_0110, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h0000_0220, 32'h0);
        bus.ramstate = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            check("to_pulse", timeout, c == TIMEOUT);
            check("to_owner", owner, 2'd1);
            check("to_wait",  bus.req_wait, 4'hF);
        end
        tick();
        check("to_idle_busy", busy, 1'b0);
        check("to_idle_to",   timeout, 1'b0);
        tick();
        check("to_next_owner", owner, 2'd2);
        check("to_next_busy",  busy, 1'b1);
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold_busy",  busy, 1'b1);
            check("hold_owner", owner, 2'd1);
            check("hold_to",    timeout, 1'b0);
        end
`endif
        clear_reqs();
        bus.ramstate = FREE;
        tick();
        tick();
        check("end_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
